alu_mul_sequencer: RTL and testbench

Multi-cycle 32×32 unsigned multiplier that acts as the initiator of the ALU control interface. It owns the `FunSel`/`A`/`B`/`WF` inputs of the 32-bit ALU and consumes `ALUOut` and `FlagsOut`. It computes the low 32 bits of the product by shift-and-add, issuing ALU 32-bit ADD and LSL operations. It derives a sticky overflow from the ALU carry flag. It sits beside the ALU in the datapath and is started by the control unit with a start/done handshake.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer_if.sv | 30 +++
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
package alu_pkg;

    localparam logic [4:0] FS_PASSA32 = 5'b10000;
    localparam logic [4:0] FS_ADD32   = 5'b10100;
    localparam logic [4:0] FS_LSL32   = 5'b11011;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEST,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Control-unit handshake and ALU control bus of the multiply sequencer.
interface alu_mul_sequencer_if;

    logic        Start;
    logic [31:0] MulA;
    logic [31:0] MulB;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    logic        Overflow;

    logic [4:0]  AluFunSel;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;

    // master: control unit plus ALU; slave: the sequencer
    modport master (
        output Start, MulA, MulB, AluOut, AluFlags,
        input  Busy, Done, Product, Overflow, AluFunSel, AluA, AluB, AluWF
    );

    modport slave (
        input  Start, MulA, MulB, AluOut, AluFlags,
        output Busy, Done, Product, Overflow, AluFunSel, AluA, AluB, AluWF
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 unsigned multiplier that drives the shared 32-bit ALU;
// low product word plus sticky overflow taken from the ALU carry flag.
module alu_mul_sequencer
    import alu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    alu_mul_sequencer_if.slave bus
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [31:0] r_p;
    logic [31:0] r_m;
    logic [31:0] r_q;
    logic        r_ovf;
    logic        r_chk;
    logic        r_from_add;
    logic [31:0] r_product;
    logic        r_overflow;
    logic        w_carry;

    assign w_carry = bus.AluFlags[FLAG_C];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_p        <= '0;
            r_m        <= '0;
            r_q        <= '0;
            r_ovf      <= 1'b0;
            r_chk      <= 1'b0;
            r_from_add <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_from_add <= (r_state == ST_ADD);
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_p   <= '0;
                        r_m   <= bus.MulA;
                        r_q   <= bus.MulB;
                        r_ovf <= 1'b0;
                        r_chk <= 1'b0;
                    end
                end
                ST_TEST: begin
                    // carry here is the bit shifted out of M by the last SHIFT
                    if (r_chk && w_carry && (r_q != '0))
                        r_ovf <= 1'b1;
                    r_chk <= 1'b0;
                    if (r_q == '0) begin
                        r_product  <= r_p;
                        r_overflow <= r_ovf;
                    end
                end
                ST_ADD: begin
                    r_p <= bus.AluOut;
                end
                ST_SHIFT: begin
                    if (r_from_add && w_carry)
                        r_ovf <= 1'b1;
                    r_m   <= bus.AluOut;
                    r_q   <= r_q >> 1;
                    r_chk <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.AluFunSel = FS_PASSA32;
        bus.AluA      = '0;
        bus.AluB      = '0;
        bus.AluWF     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start)
                    w_next = ST_TEST;
            end
            ST_TEST: begin
                bus.AluA = r_p;
                if (r_q == '0)
                    w_next = ST_DONE;
                else if (r_q[0])
                    w_next = ST_ADD;
                else
                    w_next = ST_SHIFT;
            end
            ST_ADD: begin
                bus.AluFunSel = FS_ADD32;
                bus.AluA      = r_p;
                bus.AluB      = r_m;
                bus.AluWF     = 1'b1;
                w_next        = ST_SHIFT;
            end
            ST_SHIFT: begin
                bus.AluFunSel = FS_LSL32;
                bus.AluA      = r_m;
                bus.AluWF     = 1'b1;
                w_next        = ST_TEST;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.Busy     = (r_state != ST_IDLE);
    assign bus.Done     = (r_state == ST_DONE);
    assign bus.Product  = r_product;
    assign bus.Overflow = r_overflow;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural ALU and a product/latency reference model.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    alu_mul_sequencer_if bus();

    alu_mul_sequencer dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32-bit ALU: combinational result, flags registered when WF=1
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, bus.AluA} + {1'b0, bus.AluB};
        case (bus.AluFunSel)
            FS_ADD32: bus.AluOut = alu_sum[31:0];
            FS_LSL32: bus.AluOut = {bus.AluA[30:0], 1'b0};
            default:  bus.AluOut = bus.AluA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.AluFlags <= 4'b0000;
        end else if (bus.AluWF) begin
            bus.AluFlags[FLAG_Z] <= (bus.AluOut == 32'd0);
            bus.AluFlags[FLAG_N] <= bus.AluOut[31];
            if (bus.AluFunSel == FS_ADD32) begin
                bus.AluFlags[FLAG_C] <= alu_sum[32];
                bus.AluFlags[FLAG_V] <= (bus.AluA[31] == bus.AluB[31]) &&
                                        (bus.AluOut[31] != bus.AluA[31]);
            end else begin
                bus.AluFlags[FLAG_C] <= bus.AluA[31];
                bus.AluFlags[FLAG_V] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] b);
        int k = 0;
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (b[i]) begin
                n++;
                k = i + 1;
            end
        return 2 * k + n + 2;
    endfunction

    function automatic int exp_wf_cycles(input logic [31:0] b);
        int k = 0;
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (b[i]) begin
                n++;
                k = i + 1;
            end
        return k + n;
    endfunction

    function automatic logic [63:0] full_product(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Reference model: tracks accepted operations and when Done must appear
    bit          m_busy;
    int          m_done_cyc;
    logic [31:0] m_prod;
    bit          m_ovf;
    logic [31:0] m_next_prod;
    bit          m_next_ovf;

    always @(negedge clk) begin
        bit e_done;
        if (!rst_n) begin
            m_busy = 0;
            m_prod = '0;
            m_ovf  = 0;
            check("rst_busy",     64'(bus.Busy),      64'd0);
            check("rst_done",     64'(bus.Done),      64'd0);
            check("rst_product",  64'(bus.Product),   64'd0);
            check("rst_overflow", 64'(bus.Overflow),  64'd0);
            check("rst_wf",       64'(bus.AluWF),     64'd0);
            check("rst_funsel",   64'(bus.AluFunSel), 64'(FS_PASSA32));
            check("rst_alua",     64'(bus.AluA),      64'd0);
            check("rst_alub",     64'(bus.AluB),      64'd0);
        end else begin
            e_done = m_busy && (cyc == m_done_cyc);
            if (e_done) begin
                m_prod = m_next_prod;
                m_ovf  = m_next_ovf;
            end
            check("busy",     64'(bus.Busy),     64'(m_busy));
            check("done",     64'(bus.Done),     64'(e_done));
            check("product",  64'(bus.Product),  64'(m_prod));
            check("overflow", 64'(bus.Overflow), 64'(m_ovf));
            if (!m_busy || e_done) begin
                check("idle_wf",     64'(bus.AluWF),     64'd0);
                check("idle_funsel", 64'(bus.AluFunSel), 64'(FS_PASSA32));
                check("idle_alua",   64'(bus.AluA),      64'd0);
                check("idle_alub",   64'(bus.AluB),      64'd0);
            end
            if (e_done) begin
                m_busy = 0;
            end else if (!m_busy && bus.Start) begin
                logic [63:0] full;
                full        = full_product(bus.MulA, bus.MulB);
                m_busy      = 1;
                m_done_cyc  = cyc + exp_latency(bus.MulB);
                m_next_prod = full[31:0];
                m_next_ovf  = (full[63:32] != 32'd0);
            end
        end
    end

    // Runs one operation; when poke is set, Start is pulsed while busy (incl. DONE)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_p, input bit exp_o,
                          input int exp_lat, input int exp_wf, input bit poke);
        bit seen = 0;
        int lat = 0;
        int wf = 0;
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.MulA  = a;
        bus.MulB  = b;
        for (int i = 1; i <= 120 && !seen; i++) begin
            @(posedge clk); #1;
            bus.Start = poke && (i == 3 || i == exp_lat);
            if (poke) begin
                bus.MulA = $urandom;
                bus.MulB = $urandom;
            end
            @(negedge clk);
            if (bus.AluWF) wf++;
            if (bus.Done) begin
                seen = 1;
                lat  = i;
            end
        end
        bus.Start = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("op_latency",  64'(lat),          64'(exp_lat));
            check("op_wf_count", 64'(wf),           64'(exp_wf));
            check("op_product",  64'(bus.Product),  64'(exp_p));
            check("op_overflow", 64'(bus.Overflow), 64'(exp_o));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.MulA  = '0;
        bus.MulB  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Hand-computed directed cases
        run_op(32'd3,          32'd5,          32'h0000000F, 1'b0, 10, 5,  1'b0);
        run_op(32'hDEADBEEF,   32'd0,          32'h00000000, 1'b0, 2,  0,  1'b0);
        run_op(32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1, 7,  3,  1'b0);
        run_op(32'h00010000,   32'h00010000,   32'h00000000, 1'b1, 37, 18, 1'b0);
        run_op(32'd7,          32'd6,          32'd42,       1'b0, 10, 5,  1'b0);
        run_op(32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b1, 98, 64, 1'b1);

        // Reset in cycle 5 of a 3x5 operation
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.MulA  = 32'd3;
        bus.MulB  = 32'd5;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",    64'(bus.Busy),    64'd0);
        check("abort_product", 64'(bus.Product), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        run_op(32'd3, 32'd5, 32'h0000000F, 1'b0, 10, 5, 1'b0);

        // Randomized operations, expectations from plain 64-bit arithmetic
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] full;
            a    = $urandom;
            b    = $urandom >> $urandom_range(0, 31);
            if (t % 7 == 0) a = a >> $urandom_range(16, 31);
            full = full_product(a, b);
            run_op(a, b, full[31:0], (full[63:32] != 32'd0),
                   exp_latency(b), exp_wf_cycles(b), (t % 3 == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
